debug_word_renderer: RTL
========================

# debug_word_renderer

Parametrised successor to the fixed-layout debug text writer: it snapshots a packed vector of `WORD_COUNT` debug words (CPU pipeline taps, registers) and renders each word as upper-case hex ASCII into the terminal text memory through a ready/valid write port. Beyond the current block it adds:
- configurable word count, width and layout;
- on-request or continuous refresh, plus a freeze control;
- back-pressure from the terminal port;
- changed-word highlighting: bit 7 is set on every character of a word that differs from the previous frame.

It sits between the CPU debug buses and the `Terminal` text port.

## Interface
- `WORD_COUNT`, 18: number of words rendered per frame (1..64).
- `WORD_WIDTH`, 32: bits per word; multiple of 4. `DIGITS = WORD_WIDTH/4`.
- `WORDS_PER_ROW`, 4: words per text row; `WORDS_PER_ROW*(DIGITS+1) <= COLUMNS`.
- `COLUMNS`, 80: terminal row pitch in characters.
- `BASE_ROW`, 0: first text row used.
- `ADDR_WIDTH`, 12: text address width.

Ports (clock and reset first):
- `clock` in 1: single clock. All logic is in this domain.
- `reset` in 1: asynchronous, active-low reset.
- `words` in `WORD_COUNT*WORD_WIDTH`: packed words; word i occupies `[i*WORD_WIDTH +: WORD_WIDTH]`.
- `continuous` in 1: 1 = start a new frame automatically after each frame completes; 0 = start frames only on request.
- `snapshotRequest` in 1: single-cycle pulse that requests one frame.
- `freeze` in 1: while high, no new frame starts.
- `textAddress` out `ADDR_WIDTH`: character address.
- `shouldWriteText` out 1: write valid.
- `textWriteData` out 8: character; bit 7 = highlight.
- `textReady` in 1: write accepted on a clock edge where `shouldWriteText && textReady`.
- `busy` out 1: a frame is in progress.
- `frameCount` out 16: completed frames; wraps modulo 2^16.

## Operation
FSM states:
- IDLE: wait for a frame start.
- CAPTURE: 1 cycle. Latch all of `words` into `snap`. Compute `changed[i] = prevValid && (snap[i] != prev[i])`. Clear word index, digit index, row and column.
- EMIT: present one character.
  - Digits 0..DIGITS-1 emit nibbles MSB first: 0-9 map to 0x30-0x39, A-F map to 0x41-0x46.
  - Digit DIGITS emits a space, 0x20.
  - Bit 7 is ORed with `changed[i]` on every character of word i, including its space.
- DONE: 1 cycle. Copy `snap` into `prev`, set `prevValid`, increment `frameCount`, return to IDLE.

Frame start from IDLE occurs when `!freeze && (pending || continuous)`:
- `pending` is set by `snapshotRequest` in any state.
- `pending` is cleared on entry to CAPTURE.
- A request arriving during a frame is therefore served after it; multiple requests collapse to one.

Address generation:
- `textAddress = (BASE_ROW + row)*COLUMNS + col`, built from an incrementing row-base accumulator plus a column counter. No multiplier.
- After each word's space, `col` advances.
- After `WORDS_PER_ROW` words, `col` returns to 0 and the row base advances by `COLUMNS`.
- Address arithmetic is modulo 2^`ADDR_WIDTH`; overflow is a configuration error, not checked.

Freeze behaviour:
- Asserting `freeze` mid-frame does not abort the frame. It only blocks the next start.
- `snapshotRequest` while frozen stays pending.

Reset (asynchronous, any state):
- State returns to IDLE.
- Outputs go to 0: `shouldWriteText`, `busy`, `textAddress`, `textWriteData`, `frameCount`.
- `pending` and `prevValid` are cleared, so the first frame after reset has no highlights.
- `snap` and `prev` are cleared.

## Timing
- `shouldWriteText` is high exactly in EMIT.
- Address and data are registered outputs and stay stable until accepted.
- With `textReady` held high, one character is accepted per cycle.
- Frame latency from start (IDLE to CAPTURE) is 1 + `WORD_COUNT*(DIGITS+1)` + 1 cycles, plus one cycle for each stall cycle.
- `busy` is high from CAPTURE through DONE inclusive.
- In continuous mode the gap between frames is one IDLE cycle.
- `words` is sampled only in CAPTURE; later changes do not affect the frame in progress.

## Structure
- Shared package `debug_pkg` holds:
  - the state enum (IDLE, CAPTURE, EMIT, DONE);
  - the `nibble_to_ascii` function;
  - the constants `ASCII_SPACE = 8'h20` and `HIGHLIGHT_BIT = 7`.
- One sub-module, `hex_char_mux`: combinationally selects the current nibble from `snap` by word and digit index and applies ASCII encoding and the highlight bit. Everything else stays in the top FSM.

## Test plan
- Reset, then one request with WORD_WIDTH=8, WORD_COUNT=2, WORDS_PER_ROW=2, BASE_ROW=1, COLUMNS=80, words={8'hA5,8'h3C} (word0=3C), ready high:
  - writes 0x33@80, 0x43@81, 0x20@82, 0x41@83, 0x35@84, 0x20@85;
  - `frameCount`=1, no bit 7 set.
- Second request with word1 changed to 8'hA6: word1's three characters carry bit 7 (0xC1, 0xB6, 0xA0); word0's characters do not.
- `textReady` low for 3 cycles on the second character: address and data are held unchanged and the frame takes 3 extra cycles.
- Two `snapshotRequest` pulses during a busy frame, then `freeze` high for 10 cycles after it ends: no start while frozen; exactly one further frame after release.
- Continuous=1 with WORD_COUNT=3, WORDS_PER_ROW=2: the row wraps after word 1 (word 2 at col 0, next row); `frameCount` increments every 3*(DIGITS+1)+3 cycles.
- Assert `reset` mid-EMIT: all outputs 0 asynchronously. The next frame after release has no highlights even though the words differ from the pre-reset snapshot.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared types and helpers for the debug word renderer: FSM states and
// hex-to-ASCII encoding.
package debug_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_EMIT    = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [7:0]  ASCII_SPACE   = 8'h20;
    localparam int unsigned HIGHLIGHT_BIT = 7;

    // Upper-case hex digit: 0-9 -> '0'-'9', A-F -> 'A'-'F'
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/hex_char_mux.sv
// Selects one character of the frame: the addressed nibble of the addressed word
// (or the trailing space), ASCII-encoded, with the word's change flag on bit 7.
module hex_char_mux
    import debug_pkg::*;
#(
    parameter int unsigned WORD_COUNT = 18,
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned WIDX_W     = 5,
    parameter int unsigned DIDX_W     = 4
) (
    input  logic [WORD_COUNT*WORD_WIDTH-1:0] i_words,
    input  logic [WORD_COUNT-1:0]            i_changed,
    input  logic [WIDX_W-1:0]                i_word_idx,
    input  logic [DIDX_W-1:0]                i_digit_idx,
    output logic [7:0]                       o_char_c
);

    localparam int unsigned DIGITS = WORD_WIDTH / 4;

    logic [WORD_WIDTH-1:0] w_word;
    logic                  w_highlight;
    logic [3:0]            w_nibble;
    logic [7:0]            w_base;

    // Explicit compare-and-select keeps out-of-range indices harmless
    always_comb begin
        w_word      = '0;
        w_highlight = 1'b0;
        for (int unsigned i = 0; i < WORD_COUNT; i++) begin
            if (i_word_idx == WIDX_W'(i)) begin
                w_word      = i_words[i*WORD_WIDTH +: WORD_WIDTH];
                w_highlight = i_changed[i];
            end
        end
    end

    always_comb begin
        w_nibble = 4'h0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (i_digit_idx == DIDX_W'(d)) begin
                w_nibble = w_word[(DIGITS-1-d)*4 +: 4];
            end
        end
    end

    always_comb begin
        w_base = nibble_to_ascii(w_nibble);
        if (i_digit_idx == DIDX_W'(DIGITS)) begin
            w_base = ASCII_SPACE;
        end
        o_char_c                = w_base;
        o_char_c[HIGHLIGHT_BIT] = w_base[HIGHLIGHT_BIT] | w_highlight;
    end

endmodule

// File: rtl/debug_word_renderer.sv
// Snapshots WORD_COUNT debug words and writes them as hex text into the terminal
// text memory over a ready/valid port, highlighting words changed since last frame.
module debug_word_renderer
    import debug_pkg::*;
#(
    parameter int unsigned WORD_COUNT    = 18,
    parameter int unsigned WORD_WIDTH    = 32,
    parameter int unsigned WORDS_PER_ROW = 4,
    parameter int unsigned COLUMNS       = 80,
    parameter int unsigned BASE_ROW      = 0,
    parameter int unsigned ADDR_WIDTH    = 12
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [WORD_COUNT*WORD_WIDTH-1:0] words,
    input  logic                             continuous,
    input  logic                             snapshotRequest,
    input  logic                             freeze,
    output logic [ADDR_WIDTH-1:0]            textAddress,
    output logic                             shouldWriteText,
    output logic [7:0]                       textWriteData,
    input  logic                             textReady,
    output logic                             busy,
    output logic [15:0]                      frameCount
);

    localparam int unsigned DIGITS = WORD_WIDTH / 4;
    localparam int unsigned WIDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam int unsigned DIDX_W = $clog2(DIGITS + 1);
    localparam int unsigned RIDX_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam int unsigned COL_W  = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
    localparam int unsigned SNAP_W = WORD_COUNT * WORD_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] ROW0        = ADDR_WIDTH'(BASE_ROW * COLUMNS);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP    = ADDR_WIDTH'(COLUMNS);
    localparam logic [WIDX_W-1:0]     LAST_WORD   = WIDX_W'(WORD_COUNT - 1);
    localparam logic [DIDX_W-1:0]     LAST_DIGIT  = DIDX_W'(DIGITS);
    localparam logic [RIDX_W-1:0]     LAST_IN_ROW = RIDX_W'(WORDS_PER_ROW - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [SNAP_W-1:0]       r_snap;
    logic [SNAP_W-1:0]       r_prev;
    logic [WORD_COUNT-1:0]   r_changed;
    logic                    r_prev_valid;
    logic                    r_pending;
    logic [WIDX_W-1:0]       r_word_idx;
    logic [DIDX_W-1:0]       r_digit_idx;
    logic [RIDX_W-1:0]       r_word_in_row;
    logic [COL_W-1:0]        r_col;
    logic [ADDR_WIDTH-1:0]   r_row_base;
    logic [15:0]             r_frame_count;
    logic [ADDR_WIDTH-1:0]   r_text_addr;
    logic [7:0]              r_text_data;
    logic                    r_write;
    logic                    r_busy;

    logic [WIDX_W-1:0]       w_word_nxt;
    logic [DIDX_W-1:0]       w_digit_nxt;
    logic [RIDX_W-1:0]       w_word_in_row_nxt;
    logic [COL_W-1:0]        w_col_nxt;
    logic [ADDR_WIDTH-1:0]   w_row_base_nxt;
    logic [SNAP_W-1:0]       w_mux_words;
    logic [WORD_COUNT-1:0]   w_mux_changed;
    logic [WORD_COUNT-1:0]   w_changed_now;
    logic                    w_start;
    logic                    w_capture;
    logic                    w_done;
    logic [7:0]              w_char;

    assign textAddress     = r_text_addr;
    assign shouldWriteText = r_write;
    assign textWriteData   = r_text_data;
    assign busy            = r_busy;
    assign frameCount      = r_frame_count;

    // Per-word change flags against the previous frame, used on the capture cycle
    always_comb begin
        w_changed_now = '0;
        for (int unsigned i = 0; i < WORD_COUNT; i++) begin
            w_changed_now[i] = r_prev_valid &&
                (words[i*WORD_WIDTH +: WORD_WIDTH] != r_prev[i*WORD_WIDTH +: WORD_WIDTH]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus next character position; output registers load from these
    always_comb begin
        w_state_nxt       = r_state;
        w_word_nxt        = r_word_idx;
        w_digit_nxt       = r_digit_idx;
        w_word_in_row_nxt = r_word_in_row;
        w_col_nxt         = r_col;
        w_row_base_nxt    = r_row_base;
        w_mux_words       = r_snap;
        w_mux_changed     = r_changed;
        w_start           = 1'b0;
        w_capture         = 1'b0;
        w_done            = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!freeze && (r_pending || continuous)) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // First character is built straight from the live words being latched
                w_capture         = 1'b1;
                w_state_nxt       = ST_EMIT;
                w_word_nxt        = '0;
                w_digit_nxt       = '0;
                w_word_in_row_nxt = '0;
                w_col_nxt         = '0;
                w_row_base_nxt    = ROW0;
                w_mux_words       = words;
                w_mux_changed     = w_changed_now;
            end
            ST_EMIT: begin
                if (textReady) begin
                    if (r_digit_idx == LAST_DIGIT) begin
                        if (r_word_idx == LAST_WORD) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_word_nxt  = r_word_idx + WIDX_W'(1);
                            w_digit_nxt = '0;
                            if (r_word_in_row == LAST_IN_ROW) begin
                                w_word_in_row_nxt = '0;
                                w_col_nxt         = '0;
                                w_row_base_nxt    = r_row_base + ROW_STEP;
                            end else begin
                                w_word_in_row_nxt = r_word_in_row + RIDX_W'(1);
                                w_col_nxt         = r_col + COL_W'(1);
                            end
                        end
                    end else begin
                        w_digit_nxt = r_digit_idx + DIDX_W'(1);
                        w_col_nxt   = r_col + COL_W'(1);
                    end
                end
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    hex_char_mux #(
        .WORD_COUNT (WORD_COUNT),
        .WORD_WIDTH (WORD_WIDTH),
        .WIDX_W     (WIDX_W),
        .DIDX_W     (DIDX_W)
    ) u_hex_char_mux (
        .i_words     (w_mux_words),
        .i_changed   (w_mux_changed),
        .i_word_idx  (w_word_nxt),
        .i_digit_idx (w_digit_nxt),
        .o_char_c    (w_char)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_snap        <= '0;
            r_prev        <= '0;
            r_changed     <= '0;
            r_prev_valid  <= 1'b0;
            r_pending     <= 1'b0;
            r_word_idx    <= '0;
            r_digit_idx   <= '0;
            r_word_in_row <= '0;
            r_col         <= '0;
            r_row_base    <= '0;
            r_frame_count <= '0;
            r_text_addr   <= '0;
            r_text_data   <= '0;
            r_write       <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            // A request in the start cycle is a new one and stays pending
            if (snapshotRequest) begin
                r_pending <= 1'b1;
            end else if (w_start) begin
                r_pending <= 1'b0;
            end

            if (w_capture) begin
                r_snap    <= words;
                r_changed <= w_changed_now;
            end

            if (w_done) begin
                r_prev        <= r_snap;
                r_prev_valid  <= 1'b1;
                r_frame_count <= r_frame_count + 16'd1;
            end

            r_word_idx    <= w_word_nxt;
            r_digit_idx   <= w_digit_nxt;
            r_word_in_row <= w_word_in_row_nxt;
            r_col         <= w_col_nxt;
            r_row_base    <= w_row_base_nxt;

            r_write <= (w_state_nxt == ST_EMIT);
            r_busy  <= (w_state_nxt != ST_IDLE);
            if (w_state_nxt == ST_EMIT) begin
                r_text_addr <= w_row_base_nxt + ADDR_WIDTH'(w_col_nxt);
                r_text_data <= w_char;
            end
        end
    end

endmodule
